// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, sequencing states and
// instruction field helpers used by the hazard/stall controller.
package rv_pipe_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } ctrl_state_e;

    function automatic logic [4:0] get_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic uses_rs1(input logic [31:0] inst);
        logic [6:0] opc;
        opc = inst[6:0];
        return (opc == OP) || (opc == OP_IMM) || (opc == LOAD) ||
               (opc == STORE) || (opc == BRANCH) || (opc == JALR);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] inst);
        logic [6:0] opc;
        opc = inst[6:0];
        return (opc == OP) || (opc == STORE) || (opc == BRANCH);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID,
// a dependency the forwarding network cannot satisfy in time.
module load_use_detect
    import rv_pipe_pkg::*;
(
    input  logic [31:0] inst_id,
    input  logic [31:0] inst_ex,
    input  logic        memread_ex,
    output logic        load_use
);

    logic [4:0] rd_ex;
    logic       rs1_hit;
    logic       rs2_hit;

    assign rd_ex   = get_rd(inst_ex);
    assign rs1_hit = uses_rs1(inst_id) && (get_rs1(inst_id) == rd_ex);
    assign rs2_hit = uses_rs2(inst_id) && (get_rs2(inst_id) == rd_ex);

    // x0 is never a real destination, so a load to x0 cannot create a hazard
    assign load_use = memread_ex && (rd_ex != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and data-memory waits.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_data_ID,
    input  logic [31:0]      inst_data_EX,
    input  logic             memread_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              load_use, mem_busy, take_branch, take_stall;
    logic              pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble;

    load_use_detect u_load_use_detect (
        .inst_id    (inst_data_ID),
        .inst_ex    (inst_data_EX),
        .memread_ex (memread_EX),
        .load_use   (load_use)
    );

    // A redirect is only possible when EX can hold a real instruction and memory is not freezing us
    assign mem_busy    = dmem_req_MEM && !dmem_ready;
    assign take_branch = branch_taken_EX && !mem_busy &&
                         ((state_q == RUN) || (state_q == LOAD_STALL));
    assign take_stall  = load_use && (state_q == RUN);

    always_comb begin
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        ifid_f     = 1'b0;
        idex_w     = 1'b1;
        idex_f     = 1'b0;
        exmem_w    = 1'b1;
        bubble     = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_q == MEM_WAIT) begin
            if (dmem_ready) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else begin
                {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
                bubble = 1'b1;
                if (wait_cnt_q == WAIT_MAX) timeout_d = 1'b1;
                else wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end
        end else if (mem_busy) begin
            {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
            bubble     = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_ONE;
        end else if (take_branch) begin
            ifid_f  = 1'b1;
            idex_f  = 1'b1;
            state_d = FLUSH;
        end else if (take_stall) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_f  = 1'b1;
            state_d = LOAD_STALL;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // While reset is held the pipeline is frozen and filled with NOPs
    assign pc_write     = rst_n & pc_w;
    assign ifid_write   = rst_n & ifid_w;
    assign ifid_flush   = ~rst_n | ifid_f;
    assign idex_write   = rst_n & idex_w;
    assign idex_flush   = ~rst_n | idex_f;
    assign exmem_write  = rst_n & exmem_w;
    assign memwb_bubble = ~rst_n | bubble;
    assign mem_timeout  = timeout_q;
    assign ctrl_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_w) stall_q <= stall_q + 1'b1;
            if (take_branch) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
// Counter expectations follow HAZARD_PERF_CNT_EN when it is defined.
module tb_hazard_stall_ctrl;

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] LW_X5       = 32'h0000_A283;
    localparam logic [31:0] LW_X0       = 32'h0000_A003;
    localparam logic [31:0] ADD_X6_X5X2 = 32'h0022_8333;
    localparam logic [31:0] ADD_X6_X0X2 = 32'h0020_0333;
    localparam logic [31:0] ADD_X6_X2X5 = 32'h0051_0333;
    localparam logic [31:0] LUI_X6      = 32'h0002_8337;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
    localparam logic [6:0] C_DEF    = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LDUSE  = 7'b0001110;
    localparam logic [6:0] C_RESET  = 7'b0010101;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_data_ID, inst_data_EX;
    logic        memread_EX, branch_taken_EX, dmem_req_MEM, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic        exmem_write, memwb_bubble, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_events;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_data_ID    (inst_data_ID),
        .inst_data_EX    (inst_data_EX),
        .memread_EX      (memread_EX),
        .branch_taken_EX (branch_taken_EX),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_write     (exmem_write),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout     (mem_timeout),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle before the next rising edge
    task automatic applyStimulus(input logic [31:0] id, input logic [31:0] ex, input logic mr,
                                 input logic br, input logic req, input logic rdy);
        @(negedge clk);
        inst_data_ID    = id;
        inst_data_EX    = ex;
        memread_EX      = mr;
        branch_taken_EX = br;
        dmem_req_MEM    = req;
        dmem_ready      = rdy;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [6:0] exp_ctl, input logic [1:0] exp_state);
        checkOutput({tag, "_ctl"}, 64'(ctl), 64'(exp_ctl));
        checkOutput({tag, "_state"}, 64'(ctrl_state), 64'(exp_state));
    endtask

    initial begin
        rst_n = 1'b0;
        inst_data_ID = NOP; inst_data_EX = NOP;
        memread_EX = 1'b0; branch_taken_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkCycle("reset", C_RESET, 2'd0);
        checkOutput("reset_timeout", 64'(mem_timeout), 64'd0);
        checkOutput("reset_stall_cnt", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("idle", C_DEF, 2'd0);

        // load-use on rs1, then the single bubble
        applyStimulus(ADD_X6_X5X2, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_rs1", C_LDUSE, 2'd0);
        applyStimulus(ADD_X6_X5X2, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_rs1_after", C_DEF, 2'd1);
        applyStimulus(ADD_X6_X0X2, LW_X0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_x0", C_DEF, 2'd0);
        applyStimulus(ADD_X6_X2X5, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_rs2", C_LDUSE, 2'd0);
        applyStimulus(ADD_X6_X2X5, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_rs2_after", C_DEF, 2'd1);
        applyStimulus(LUI_X6, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("lu_lui", C_DEF, 2'd0);

        // taken branch, then branch racing a load-use
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("br", C_BRANCH, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("br_flush", C_DEF, 2'd3);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("br_run", C_DEF, 2'd0);
        checkOutput("flush_cnt_1", 64'(flush_events), PERF ? 64'd1 : 64'd0);
        applyStimulus(ADD_X6_X5X2, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCycle("br_lu", C_BRANCH, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("br_lu_flush", C_DEF, 2'd3);

        // three-cycle memory wait
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("mw1", C_FREEZE, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("mw2", C_FREEZE, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("mw3", C_FREEZE, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("mw_release", C_DEF, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("mw_run", C_DEF, 2'd0);
        checkOutput("mw_timeout", 64'(mem_timeout), 64'd0);
        checkOutput("stall_cnt_5", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);

        // memory wait with a branch held: freeze first, redirect after release
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCycle("mwbr1", C_FREEZE, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCycle("mwbr2", C_FREEZE, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCycle("mwbr_release", C_DEF, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("mwbr_branch", C_BRANCH, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("mwbr_flush", C_DEF, 2'd3);
        checkOutput("stall_cnt_7", 64'(stall_cycles), PERF ? 64'd7 : 64'd0);
        checkOutput("flush_cnt_3", 64'(flush_events), PERF ? 64'd3 : 64'd0);

        // timeout: one RUN freeze cycle then four MEM_WAIT cycles before the flag rises
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("to_enter", C_FREEZE, 2'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("to_pending", 64'(mem_timeout), 64'd0);
        end
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("to_set", 64'(mem_timeout), 64'd1);
        checkCycle("to_hold", C_FREEZE, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("to_release", C_DEF, 2'd2);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_sticky", 64'(mem_timeout), 64'd1);
        checkCycle("to_run", C_DEF, 2'd0);

        // asynchronous reset in the middle of a memory wait
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("rst_pre", C_FREEZE, 2'd2);
        rst_n = 1'b0;
        #1;
        checkCycle("rst_mid", C_RESET, 2'd0);
        checkOutput("rst_mid_timeout", 64'(mem_timeout), 64'd0);
        checkOutput("rst_mid_flush_cnt", 64'(flush_events), 64'd0);
        dmem_req_MEM = 1'b0;
        dmem_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkCycle("rst_release", C_DEF, 2'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("rst_run", C_DEF, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
